// File: rtl/shift_ctrl.sv
// Two-stage valid/ready control wrapper around an external combinational barrel shifter.
// Optional rotate support (rotr/rotrv) is enabled by defining SHIFT_CTRL_ROTATE_EN.
module shift_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic        rot,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  rd,
    output logic [31:0] sh_data,
    output logic [4:0]  sh_sa,
    output logic        sh_right,
    output logic        sh_arith,
    input  logic [31:0] sh_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnSrlv = 6'b000110;
    localparam logic [5:0] FnSrav = 6'b000111;

    logic        s1_valid;
    logic [4:0]  s1_rd;
    logic        s1_illegal;
    logic        s2_free;
    logic        s1_adv;
    logic        accept;

    logic [31:0] dec_data;
    logic [4:0]  dec_sa;
    logic        dec_right;
    logic        dec_arith;
    logic        dec_illegal;
    logic        dec_rot;
    logic [31:0] result;

    // Only the low five bits of rs select a variable shift amount.
`ifdef SHIFT_CTRL_ROTATE_EN
    logic        unused_ok;
    assign unused_ok = ^rs_val[31:5];
`else
    logic        unused_ok;
    assign unused_ok = ^{rs_val[31:5], rot};
`endif

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_sa      = '0;
        dec_right   = 1'b0;
        dec_arith   = 1'b0;
        dec_illegal = 1'b0;
        dec_rot     = 1'b0;
        case (funct)
            FnSll:  dec_sa = shamt;
            FnSrl:  begin dec_sa = shamt;       dec_right = 1'b1; end
            FnSra:  begin dec_sa = shamt;       dec_right = 1'b1; dec_arith = 1'b1; end
            FnSllv: dec_sa = rs_val[4:0];
            FnSrlv: begin dec_sa = rs_val[4:0]; dec_right = 1'b1; end
            FnSrav: begin dec_sa = rs_val[4:0]; dec_right = 1'b1; dec_arith = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
`ifdef SHIFT_CTRL_ROTATE_EN
        // Rotates drive the shifter as a logical right shift; stage 2 ORs in the wrapped bits.
        if (rot && !dec_illegal) begin
            if (funct == FnSrl || funct == FnSrlv) begin
                dec_rot = 1'b1;
            end else begin
                dec_illegal = 1'b1;
            end
        end
`endif
        if (dec_illegal) begin
            dec_sa    = '0;
            dec_right = 1'b0;
            dec_arith = 1'b0;
            dec_rot   = 1'b0;
        end
        dec_data = dec_illegal ? 32'h0 : rt_val;
    end

`ifdef SHIFT_CTRL_ROTATE_EN
    logic s1_rot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rot <= 1'b0;
        end else if (accept) begin
            s1_rot <= dec_rot;
        end
    end

    always_comb begin
        result = s1_illegal ? 32'h0 : sh_o;
        if (s1_rot) begin
            if (sh_sa == 5'd0) begin
                result = sh_data;
            end else begin
                result = sh_o | (sh_data << (6'd32 - {1'b0, sh_sa}));
            end
        end
    end
`else
    logic unused_rot;
    assign unused_rot = dec_rot;

    always_comb begin
        result = s1_illegal ? 32'h0 : sh_o;
    end
`endif

    // Stage 1: operands only change on accept, so sh_* hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            sh_data    <= '0;
            sh_sa      <= '0;
            sh_right   <= 1'b0;
            sh_arith   <= 1'b0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                sh_data    <= dec_data;
                sh_sa      <= dec_sa;
                sh_right   <= dec_right;
                sh_arith   <= dec_arith;
                s1_rd      <= rd;
                s1_illegal <= dec_illegal;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: result register for writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid   <= 1'b1;
                out_result  <= result;
                out_rd      <= s1_rd;
                out_illegal <= s1_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl with a behavioural barrel shifter on sh_*.
// Rotate expectations follow SHIFT_CTRL_ROTATE_EN.
module tb_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic        rot = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [4:0]  rd = '0;
    logic [31:0] sh_data;
    logic [4:0]  sh_sa;
    logic        sh_right;
    logic        sh_arith;
    logic [31:0] sh_o;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int passed = 0;
    int total  = 0;

    shift_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .rot(rot), .rs_val(rs_val), .rt_val(rt_val),
        .rd(rd), .sh_data(sh_data), .sh_sa(sh_sa), .sh_right(sh_right),
        .sh_arith(sh_arith), .sh_o(sh_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // External barrel shifter.
    always_comb begin
        if (!sh_right)     sh_o = sh_data << sh_sa;
        else if (sh_arith) sh_o = 32'($signed(sh_data) >>> sh_sa);
        else               sh_o = sh_data >> sh_sa;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] s, input logic r,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d);
        in_valid = 1'b1;
        funct    = f;
        shamt    = s;
        rot      = r;
        rs_val   = rs;
        rt_val   = rt;
        rd       = d;
    endtask

    task automatic send(input logic [5:0] f, input logic [4:0] s, input logic r,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d);
        drive(f, s, r, rs, rt, d);
        tick();
        in_valid = 1'b0;
        rot      = 1'b0;
    endtask

    // Stream of mixed ops with hand-computed results.
    logic [5:0]  s_fn [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h00, 6'h07};
    logic [4:0]  s_sh [8] = '{5'd8, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] s_rs [8] = '{32'h0, 32'h0, 32'h0, 32'h21, 32'h3F, 32'h1F, 32'h0, 32'h0};
    logic [31:0] s_rt [8] = '{32'h000000AB, 32'hF0000000, 32'hF0000000, 32'h40000001,
                              32'h80000000, 32'h80000000, 32'h12345678, 32'h87654321};
    logic [31:0] s_ex [8] = '{32'h0000AB00, 32'h0F000000, 32'hFF000000, 32'h80000002,
                              32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h87654321};

    initial begin
        int acc;
        int oidx;
        bit seen_low;
        logic [31:0] held_res;
        logic [31:0] held_data;
        logic [4:0]  held_rd;

        // Reset values
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sh_data", sh_data, 32'h0);
        chk("rst_sh_sa", 32'(sh_sa), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // sra with latency check
        out_ready = 1'b1;
        send(6'b000011, 5'd4, 1'b0, 32'h0, 32'h80000010, 5'd5);
        chk("sra_sh_data", sh_data, 32'h80000010);
        chk("sra_sh_sa", 32'(sh_sa), 32'd4);
        chk("sra_sh_right", 32'(sh_right), 32'd1);
        chk("sra_sh_arith", 32'(sh_arith), 32'd1);
        chk("sra_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        chk("sra_out_valid", 32'(out_valid), 32'd1);
        chk("sra_result", out_result, 32'hF8000001);
        chk("sra_rd", 32'(out_rd), 32'd5);
        chk("sra_illegal", 32'(out_illegal), 32'd0);
        tick();
        chk("sra_drained", 32'(out_valid), 32'd0);

        // srlv then sllv back to back
        send(6'b000110, 5'd0, 1'b0, 32'h24, 32'h80000010, 5'd12);
        drive(6'b000100, 5'd0, 1'b0, 32'h1F, 32'h00000003, 5'd13);
        tick();
        in_valid = 1'b0;
        chk("srlv_result", out_result, 32'h08000001);
        chk("srlv_rd", 32'(out_rd), 32'd12);
        tick();
        chk("sllv_valid", 32'(out_valid), 32'd1);
        chk("sllv_result", out_result, 32'h80000000);
        chk("sllv_rd", 32'(out_rd), 32'd13);
        tick();

        // Stream with a 3-cycle stall
        acc = 0;
        oidx = 0;
        seen_low = 1'b0;
        held_res = '0;
        held_data = '0;
        held_rd = '0;
        for (int it = 0; it < 40 && oidx < 8; it++) begin
            out_ready = (it >= 3 && it <= 5) ? 1'b0 : 1'b1;
            if (acc < 8) drive(s_fn[acc], s_sh[acc], 1'b0, s_rs[acc], s_rt[acc], 5'(acc + 1));
            else in_valid = 1'b0;
            #1;
            if (!in_ready) seen_low = 1'b1;
            if (it == 3) begin
                held_res  = out_result;
                held_rd   = out_rd;
                held_data = sh_data;
            end
            if (it == 4 || it == 5) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_result", out_result, held_res);
                chk("stall_rd", 32'(out_rd), 32'(held_rd));
                chk("stall_sh_data", sh_data, held_data);
            end
            if (it == 5) chk("full_in_ready", 32'(in_ready), 32'd0);
            if (it == 6) chk("release_in_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                chk("stream_result", out_result, s_ex[oidx]);
                chk("stream_rd", 32'(out_rd), 32'(oidx + 1));
                oidx++;
            end
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(oidx), 32'd8);
        chk("stream_in_ready_low", 32'(seen_low), 32'd1);
        chk("stream_no_extra", 32'(out_valid), 32'd0);
        tick();

        // Illegal funct followed by legal sll
        send(6'b100000, 5'd3, 1'b0, 32'h0, 32'h0000FFFF, 5'd9);
        chk("illegal_sh_data", sh_data, 32'h0);
        chk("illegal_sh_sa", 32'(sh_sa), 32'd0);
        chk("illegal_sh_right", 32'(sh_right), 32'd0);
        drive(6'b000000, 5'd1, 1'b0, 32'h0, 32'h1, 5'd10);
        tick();
        in_valid = 1'b0;
        chk("illegal_flag", 32'(out_illegal), 32'd1);
        chk("illegal_result", out_result, 32'h0);
        chk("illegal_rd", 32'(out_rd), 32'd9);
        tick();
        chk("after_illegal_result", out_result, 32'h2);
        chk("after_illegal_flag", 32'(out_illegal), 32'd0);
        chk("after_illegal_rd", 32'(out_rd), 32'd10);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        send(6'b000000, 5'd0, 1'b0, 32'h0, 32'h5, 5'd14);
        drive(6'b000000, 5'd1, 1'b0, 32'h0, 32'h6, 5'd15);
        tick();
        in_valid = 1'b0;
        chk("full_before_rst_ready", 32'(in_ready), 32'd0);
        chk("full_before_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("postrst_no_stale", 32'(out_valid), 32'd0);
        send(6'b000000, 5'd2, 1'b0, 32'h0, 32'h1, 5'd11);
        tick();
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_result", out_result, 32'h4);
        chk("postrst_rd", 32'(out_rd), 32'd11);
        tick();

        // Rotate behaviour
`ifdef SHIFT_CTRL_ROTATE_EN
        send(6'b000010, 5'd4, 1'b1, 32'h0, 32'h0000001F, 5'd16);
        chk("rotr_sh_right", 32'(sh_right), 32'd1);
        chk("rotr_sh_arith", 32'(sh_arith), 32'd0);
        tick();
        chk("rotr_result", out_result, 32'hF0000001);
        chk("rotr_illegal", 32'(out_illegal), 32'd0);
        send(6'b000010, 5'd0, 1'b1, 32'h0, 32'h0000001F, 5'd17);
        tick();
        chk("rotr_zero_result", out_result, 32'h0000001F);
        send(6'b000110, 5'd0, 1'b1, 32'h4, 32'h0000001F, 5'd18);
        tick();
        chk("rotrv_result", out_result, 32'hF0000001);
        send(6'b000011, 5'd4, 1'b1, 32'h0, 32'h0000001F, 5'd19);
        tick();
        chk("sra_rot_illegal", 32'(out_illegal), 32'd1);
        chk("sra_rot_result", out_result, 32'h0);
`else
        send(6'b000010, 5'd4, 1'b1, 32'h0, 32'h0000001F, 5'd16);
        tick();
        chk("srl_rot_ignored", out_result, 32'h00000001);
        chk("srl_rot_legal", 32'(out_illegal), 32'd0);
        send(6'b000011, 5'd4, 1'b1, 32'h0, 32'h0000001F, 5'd19);
        tick();
        chk("sra_rot_ignored", out_result, 32'h00000001);
        chk("sra_rot_legal", 32'(out_illegal), 32'd0);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
